// File: rtl/ex_sim_axi4stream_slv_sink.sv
// AXI4-Stream sink for example benches: programmable tready backpressure, incrementing-data checker, handshake monitor.
// Optional build macro AXIS_SINK_TLAST_EN adds s_axis_tlast / pkt_cnt and packet-aware sequencing.
module ex_sim_axi4stream_slv_sink #(
    parameter int          DATA_WIDTH = 8,
    parameter int          CNT_WIDTH  = 32,
    parameter logic [15:0] LFSR_SEED  = 16'hACE1
) (
    input  logic                  aclk,
    input  logic                  areset,
    input  logic                  s_axis_tvalid,
    output logic                  s_axis_tready,
    input  logic [DATA_WIDTH-1:0] s_axis_tdata,
`ifdef AXIS_SINK_TLAST_EN
    input  logic                  s_axis_tlast,
    output logic [CNT_WIDTH-1:0]  pkt_cnt,
`endif
    input  logic [1:0]            cfg_ready_mode,
    input  logic [7:0]            cfg_period,
    input  logic [DATA_WIDTH-1:0] cfg_exp_seed,
    input  logic                  cfg_check_en,
    input  logic                  clr,
    output logic [CNT_WIDTH-1:0]  beat_cnt,
    output logic [CNT_WIDTH-1:0]  err_cnt,
    output logic                  err_first_vld,
    output logic [DATA_WIDTH-1:0] err_first_exp,
    output logic [DATA_WIDTH-1:0] err_first_got,
    output logic                  proto_err
);

    typedef enum logic [1:0] {
        MODE_ALWAYS   = 2'd0,
        MODE_NEVER    = 2'd1,
        MODE_LFSR     = 2'd2,
        MODE_PERIODIC = 2'd3
    } ready_mode_e;

    localparam logic [15:0]           LFSR_MASK = 16'hB400;
    localparam logic [DATA_WIDTH-1:0] DATA_ONE  = DATA_WIDTH'(1);
    localparam logic [CNT_WIDTH-1:0]  CNT_ONE   = CNT_WIDTH'(1);

    function automatic logic [CNT_WIDTH-1:0] sat_inc(input logic [CNT_WIDTH-1:0] v);
        return (&v) ? v : v + CNT_ONE;
    endfunction

    logic [15:0]           lfsr_q, lfsr_d;
    logic [7:0]            period_q, period_d;
    logic                  tready_q, tready_d;
    logic [CNT_WIDTH-1:0]  beat_q, beat_d, err_q, err_d;
    logic                  fv_q, fv_d;
    logic [DATA_WIDTH-1:0] fe_q, fe_d, fg_q, fg_d;
    logic [DATA_WIDTH-1:0] exp_q, exp_d;
    logic                  stall_q, stall_d;
    logic [DATA_WIDTH-1:0] hold_q, hold_d;
    logic                  proto_q, proto_d;
    logic                  xfer, mismatch, proto_viol;
`ifdef AXIS_SINK_TLAST_EN
    logic [CNT_WIDTH-1:0]  pkt_q, pkt_d;
    logic                  hold_last_q, hold_last_d;
`endif

    // Backpressure generators free-run in every mode so switching modes never restarts them.
    always_comb begin
        lfsr_d   = {1'b0, lfsr_q[15:1]} ^ (lfsr_q[0] ? LFSR_MASK : 16'h0000);
        period_d = (period_q >= cfg_period) ? 8'd0 : period_q + 8'd1;
        tready_d = 1'b0;
        case (ready_mode_e'(cfg_ready_mode))
            MODE_ALWAYS:   tready_d = 1'b1;
            MODE_NEVER:    tready_d = 1'b0;
            MODE_LFSR:     tready_d = lfsr_d[0];
            MODE_PERIODIC: tready_d = (period_q == cfg_period);
            default:       tready_d = 1'b0;
        endcase
    end

    assign xfer     = s_axis_tvalid && tready_q;
    assign mismatch = cfg_check_en && (s_axis_tdata != exp_q);
`ifdef AXIS_SINK_TLAST_EN
    assign proto_viol = stall_q && (!s_axis_tvalid || (s_axis_tdata != hold_q)
                                    || (s_axis_tlast != hold_last_q));
`else
    assign proto_viol = stall_q && (!s_axis_tvalid || (s_axis_tdata != hold_q));
`endif

    // NOTE: every next-state signal gets its hold value first, so no path leaves one unassigned (no latch).
    always_comb begin
        beat_d  = beat_q;
        err_d   = err_q;
        fv_d    = fv_q;
        fe_d    = fe_q;
        fg_d    = fg_q;
        exp_d   = exp_q;
        stall_d = s_axis_tvalid && !tready_q;
        hold_d  = s_axis_tdata;
        proto_d = proto_q || proto_viol;
`ifdef AXIS_SINK_TLAST_EN
        pkt_d       = pkt_q;
        hold_last_d = s_axis_tlast;
`endif
        if (clr) begin
            beat_d  = '0;
            err_d   = '0;
            fv_d    = 1'b0;
            fe_d    = '0;
            fg_d    = '0;
            exp_d   = cfg_exp_seed;
            stall_d = 1'b0;
            hold_d  = '0;
            proto_d = 1'b0;
`ifdef AXIS_SINK_TLAST_EN
            pkt_d       = '0;
            hold_last_d = 1'b0;
`endif
        end else if (xfer) begin
            beat_d = sat_inc(beat_q);
            if (mismatch) begin
                err_d = sat_inc(err_q);
                if (!fv_q) begin
                    fv_d = 1'b1;
                    fe_d = exp_q;
                    fg_d = s_axis_tdata;
                end
            end
            exp_d = s_axis_tdata + DATA_ONE;
`ifdef AXIS_SINK_TLAST_EN
            if (s_axis_tlast) begin
                pkt_d = sat_inc(pkt_q);
                exp_d = cfg_exp_seed;
            end
`endif
        end
    end

    // NOTE: state registers use non-blocking assignment so all flops update from pre-edge values.
    always_ff @(posedge aclk) begin
        if (areset) begin
            lfsr_q   <= LFSR_SEED;
            period_q <= 8'd0;
            tready_q <= 1'b0;
            beat_q   <= '0;
            err_q    <= '0;
            fv_q     <= 1'b0;
            fe_q     <= '0;
            fg_q     <= '0;
            exp_q    <= cfg_exp_seed;
            stall_q  <= 1'b0;
            hold_q   <= '0;
            proto_q  <= 1'b0;
`ifdef AXIS_SINK_TLAST_EN
            pkt_q       <= '0;
            hold_last_q <= 1'b0;
`endif
        end else begin
            lfsr_q   <= lfsr_d;
            period_q <= period_d;
            tready_q <= tready_d;
            beat_q   <= beat_d;
            err_q    <= err_d;
            fv_q     <= fv_d;
            fe_q     <= fe_d;
            fg_q     <= fg_d;
            exp_q    <= exp_d;
            stall_q  <= stall_d;
            hold_q   <= hold_d;
            proto_q  <= proto_d;
`ifdef AXIS_SINK_TLAST_EN
            pkt_q       <= pkt_d;
            hold_last_q <= hold_last_d;
`endif
        end
    end

    assign s_axis_tready = tready_q;
    assign beat_cnt      = beat_q;
    assign err_cnt       = err_q;
    assign err_first_vld = fv_q;
    assign err_first_exp = fe_q;
    assign err_first_got = fg_q;
    assign proto_err     = proto_q;
`ifdef AXIS_SINK_TLAST_EN
    assign pkt_cnt       = pkt_q;
`endif

endmodule
